sample_scheduler: RTL

Sequencer for the shared sample bus (`output_sample` / `channel_select` / `sample_data`) that pin controllers and the ADC controller drive. At a programmable rate it scans a list of up to 8 channel slots, polls each source over the bus, and pushes the results into a 256-word FIFO. Software reads that FIFO over EBI. The block sits on the EBI register bus beside the pin, ADC, DAC and crossbar controllers and is the sole driver of the bus-select signals.

---
 rtl/sample_scheduler.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sample_scheduler.sv
// sample_scheduler: scans up to 8 channel slots at a programmable rate,
// polls each source over the shared sample bus and queues results in a FIFO.
// Build option: define SAMPLE_TAG_EN to tag FIFO words with the slot index.
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   enable, addr          - EBI select and word address
//   data_in, data_wr      - EBI write data and strobe
//   data_rd, data_out     - EBI read strobe and wired-OR read data
//   output_sample         - bus request to sample sources
//   channel_select        - channel id being polled
//   sample_data           - wired-OR sample bus from sources
module sample_scheduler #(
  parameter int POSITION = 300,
  parameter int FIFO_AW  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [18:0] addr,
  input  logic [15:0] data_in,
  input  logic        data_wr,
  input  logic        data_rd,
  output logic [15:0] data_out,
  output logic        output_sample,
  output logic [7:0]  channel_select,
  input  logic [15:0] sample_data
);

  localparam logic [FIFO_AW:0] DEPTH_C =
    {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    SETTLE,
    CAPTURE
  } state_t;

  // Address decode
  logic [18:0] off;
  logic        in_range;
  logic [3:0]  reg_sel;

  assign off      = addr - 19'(POSITION);
  assign in_range = (addr >= 19'(POSITION)) &&
                    (off < 19'd16);
  assign reg_sel  = off[3:0];

  // Strobe edge detection
  logic wr_hit, wr_hit_q, wr_take;
  logic rd_fifo, rd_fifo_q, pop_evt;

  assign wr_hit  = enable & data_wr & in_range;
  assign wr_take = wr_hit & ~wr_hit_q;
  assign rd_fifo = enable & data_rd &
                   (addr == 19'(POSITION + 5));
  // Pop on strobe release so the word is stable
  // for the whole read access.
  assign pop_evt = rd_fifo_q & ~rd_fifo;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_hit_q  <= 1'b0;
      rd_fifo_q <= 1'b0;
    end else begin
      wr_hit_q  <= wr_hit;
      rd_fifo_q <= rd_fifo;
    end
  end

  // Configuration registers
  logic        run_q;
  logic [15:0] div_q;
  logic [3:0]  nslots_q;
  logic [7:0]  slot_q [8];
  logic [3:0]  ns_wr;
  logic        clr;

  assign ns_wr = (data_in[3:0] > 4'd8) ?
                 4'd8 : data_in[3:0];
  assign clr   = wr_take && (reg_sel == 4'd0) &&
                 data_in[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q    <= 1'b0;
      div_q    <= 16'hFFFF;
      nslots_q <= 4'd0;
      for (int i = 0; i < 8; i++)
        slot_q[i] <= 8'd0;
    end else if (wr_take) begin
      case (reg_sel)
        4'd0: run_q    <= data_in[0];
        4'd1: div_q    <= data_in;
        4'd2: nslots_q <= ns_wr;
        4'd8, 4'd9, 4'd10, 4'd11,
        4'd12, 4'd13, 4'd14, 4'd15:
          slot_q[reg_sel[2:0]] <= data_in[7:0];
        default: ;
      endcase
    end
  end

  // Scan-rate tick
  logic [15:0] tick_cnt;
  logic        active, tick;

  assign active = run_q && (nslots_q != 4'd0);
  // >= keeps the counter sane if DIV is lowered
  // below the current count.
  assign tick   = active && (tick_cnt >= div_q);

  always_ff @(posedge clk) begin
    if (reset || !active)
      tick_cnt <= 16'd0;
    else if (tick)
      tick_cnt <= 16'd0;
    else
      tick_cnt <= tick_cnt + 16'd1;
  end

  // Scan FSM
  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] ch_q, ch_d;
  logic [3:0] idx_inc;
  logic       push_req;
  logic       busy;

  assign idx_inc = {1'b0, idx_q} + 4'd1;
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      ch_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ch_d     = ch_q;
    push_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SELECT;
          idx_d   = 3'd0;
          ch_d    = slot_q[0];
        end
      end
      SELECT:  state_d = SETTLE;
      SETTLE:  state_d = CAPTURE;
      CAPTURE: begin
        push_req = 1'b1;
        if (idx_inc < nslots_q) begin
          state_d = SELECT;
          idx_d   = idx_inc[2:0];
          ch_d    = slot_q[idx_inc[2:0]];
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Stopping aborts the scan and drops the
    // capture in flight.
    if (!run_q) begin
      state_d  = IDLE;
      push_req = 1'b0;
    end
  end

  assign output_sample  = busy;
  assign channel_select = busy ? ch_q : 8'd0;

  // FIFO
  logic [15:0]      mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0] count_q;
  logic             full, empty;
  logic             do_push, do_pop, ovf_set;
  logic             ovf_q, ovr_q;
  logic [15:0]      push_word;

`ifdef SAMPLE_TAG_EN
  logic tag_unused;
  assign tag_unused = ^sample_data[15:13];
  assign push_word  = {idx_q, sample_data[12:0]};
`else
  assign push_word  = sample_data;
`endif

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_pop  = pop_evt & ~empty;
  // A pop in the same cycle frees the slot, so a
  // push into a full FIFO still lands.
  assign do_push = push_req & ~clr &
                   (~full | do_pop);
  assign ovf_set = push_req & ~clr &
                   full & ~do_pop;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr_q] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (do_push)
        wptr_q <= wptr_q + 1'b1;
      if (do_pop)
        rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      if (ovf_set)
        ovf_q <= 1'b1;
      if (tick && busy)
        ovr_q <= 1'b1;
    end
  end

  // Read mux
  always_comb begin
    data_out = 16'd0;
    if (enable && data_rd && in_range) begin
      case (reg_sel)
        4'd0: data_out = {15'd0, run_q};
        4'd1: data_out = div_q;
        4'd2: data_out = {12'd0, nslots_q};
        4'd3: data_out = {11'd0, full, empty,
                          ovr_q, ovf_q, busy};
        4'd4: data_out = 16'(count_q);
        4'd5: data_out = empty ? 16'd0 :
                         mem[rptr_q];
        4'd8, 4'd9, 4'd10, 4'd11,
        4'd12, 4'd13, 4'd14, 4'd15:
          data_out = {8'd0, slot_q[reg_sel[2:0]]};
        default: data_out = 16'd0;
      endcase
    end
  end

endmodule
